// File: rtl/histogram_frame_sequencer.sv
// Frame-level sequencer for the pixel histogram block: raster-scans the binary frame buffer,
// runs the histogram readout and reduces the streamed x/y bins to a peak index and count per axis.
module histogram_frame_sequencer #(
  parameter int unsigned IMWIDTH  = 240,
  parameter int unsigned IMHEIGHT = 180,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pixAddr,
  input  logic              pixRdData,
  output logic [7:0]        xAddress,
  output logic [7:0]        yAddress,
  output logic              pixelData,
  output logic              startHistogram,
  output logic              readHistogram,
  input  logic [7:0]        xHistogramIn,
  input  logic [7:0]        yHistogramIn,
  input  logic              xValidIn,
  input  logic              yValidIn,
  output logic [7:0]        xPeak,
  output logic [7:0]        yPeak,
  output logic [7:0]        xPeakCount,
  output logic [7:0]        yPeakCount
);

  // READ lasts RD_LEN+1 cycles: RD_LEN with readHistogram high, plus one to catch the last beat
  localparam int unsigned RD_LEN   = ((IMWIDTH > IMHEIGHT) ? IMWIDTH : IMHEIGHT) + 1;
  localparam int unsigned RD_CNT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [7:0]          x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          xa_q, xa_d, ya_q, ya_d;
  logic                hist_en_q, hist_en_d;
  logic                drain_q, drain_d;
  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [7:0]          x_max_q, x_max_d, x_idx_q, x_idx_d, x_bin_q, x_bin_d;
  logic [7:0]          y_max_q, y_max_d, y_idx_q, y_idx_d, y_bin_q, y_bin_d;
  logic [7:0]          x_peak_q, x_peak_d, x_cnt_q, x_cnt_d;
  logic [7:0]          y_peak_q, y_peak_d, y_cnt_q, y_cnt_d;

  logic last_pix;
  assign last_pix = (x_q == 8'(IMWIDTH - 1)) && (y_q == 8'(IMHEIGHT - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)    state_d = ST_SCAN;
      ST_SCAN:  if (last_pix) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q)  state_d = ST_READ;
      ST_READ:  if (rd_cnt_q == RD_CNT_W'(RD_LEN)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values, registered below
  always_comb begin
    x_d       = '0;
    y_d       = '0;
    addr_d    = '0;
    xa_d      = x_q;
    ya_d      = y_q;
    hist_en_d = (state_q == ST_SCAN);
    drain_d   = 1'b0;
    rd_cnt_d  = '0;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    x_max_d   = x_max_q;
    x_idx_d   = x_idx_q;
    x_bin_d   = x_bin_q;
    y_max_d   = y_max_q;
    y_idx_d   = y_idx_q;
    y_bin_d   = y_bin_q;
    x_peak_d  = x_peak_q;
    x_cnt_d   = x_cnt_q;
    y_peak_d  = y_peak_q;
    y_cnt_d   = y_cnt_q;

    if (state_q == ST_SCAN && state_d == ST_SCAN) begin
      addr_d = addr_q + ADDR_W'(1);
      if (x_q == 8'(IMWIDTH - 1)) begin
        x_d = '0;
        y_d = y_q + 8'(1);
      end else begin
        x_d = x_q + 8'(1);
        y_d = y_q;
      end
    end

    if (state_q == ST_DRAIN) drain_d  = ~drain_q;
    if (state_q == ST_READ)  rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
    rd_en_d = (state_d == ST_READ) && (rd_cnt_d < RD_CNT_W'(RD_LEN));

    if (state_d == ST_READ && state_q != ST_READ) begin
      x_max_d = '0; x_idx_d = '0; x_bin_d = '0;
      y_max_d = '0; y_idx_d = '0; y_bin_d = '0;
    end

    // Strict compare keeps the lowest index on ties; bin index counts valid beats only
    if (state_q == ST_READ) begin
      if (xValidIn) begin
        if (xHistogramIn > x_max_q) begin
          x_max_d = xHistogramIn;
          x_idx_d = x_bin_q;
        end
        x_bin_d = x_bin_q + 8'(1);
      end
      if (yValidIn) begin
        if (yHistogramIn > y_max_q) begin
          y_max_d = yHistogramIn;
          y_idx_d = y_bin_q;
        end
        y_bin_d = y_bin_q + 8'(1);
      end
    end

    if (state_q == ST_READ && state_d == ST_DONE) begin
      x_peak_d = x_idx_d;
      x_cnt_d  = x_max_d;
      y_peak_d = y_idx_d;
      y_cnt_d  = y_max_d;
    end else if (state_q == ST_IDLE && state_d == ST_SCAN) begin
      x_peak_d = '0;
      x_cnt_d  = '0;
      y_peak_d = '0;
      y_cnt_d  = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      xa_q      <= '0;
      ya_q      <= '0;
      hist_en_q <= 1'b0;
      drain_q   <= 1'b0;
      rd_cnt_q  <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x_max_q   <= '0;
      x_idx_q   <= '0;
      x_bin_q   <= '0;
      y_max_q   <= '0;
      y_idx_q   <= '0;
      y_bin_q   <= '0;
      x_peak_q  <= '0;
      x_cnt_q   <= '0;
      y_peak_q  <= '0;
      y_cnt_q   <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      xa_q      <= xa_d;
      ya_q      <= ya_d;
      hist_en_q <= hist_en_d;
      drain_q   <= drain_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      x_max_q   <= x_max_d;
      x_idx_q   <= x_idx_d;
      x_bin_q   <= x_bin_d;
      y_max_q   <= y_max_d;
      y_idx_q   <= y_idx_d;
      y_bin_q   <= y_bin_d;
      x_peak_q  <= x_peak_d;
      x_cnt_q   <= x_cnt_d;
      y_peak_q  <= y_peak_d;
      y_cnt_q   <= y_cnt_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pixAddr        = addr_q;
  assign xAddress       = xa_q;
  assign yAddress       = ya_q;
  assign pixelData      = pixRdData;
  assign startHistogram = hist_en_q;
  assign readHistogram  = rd_en_q;
  assign xPeak          = x_peak_q;
  assign yPeak          = y_peak_q;
  assign xPeakCount     = x_cnt_q;
  assign yPeakCount     = y_cnt_q;

endmodule

// File: tb/tb_histogram_frame_sequencer.sv
// Directed bench for histogram_frame_sequencer on a 4x3 frame with a frame-buffer
// and histogram-block model; expected timelines and peaks are hand-computed.
module tb_histogram_frame_sequencer;

  localparam int IMW    = 4;
  localparam int IMH    = 3;
  localparam int AW     = 8;
  localparam int NPIX   = IMW * IMH;        // 12
  localparam int RLEN   = 5;                // max(4,3)+1
  localparam int K_DONE = NPIX + RLEN + 3;  // 20 edges after the start-sampling edge

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] pixAddr;
  logic          pixRdData = 1'b0;
  logic [7:0]    xAddress, yAddress;
  logic          pixelData, startHistogram, readHistogram;
  logic [7:0]    xHistogramIn = 8'd0, yHistogramIn = 8'd0;
  logic          xValidIn = 1'b0, yValidIn = 1'b0;
  logic [7:0]    xPeak, yPeak, xPeakCount, yPeakCount;

  always #5 clk = ~clk;

  histogram_frame_sequencer #(
    .IMWIDTH (IMW),
    .IMHEIGHT(IMH),
    .ADDR_W  (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .pixAddr       (pixAddr),
    .pixRdData     (pixRdData),
    .xAddress      (xAddress),
    .yAddress      (yAddress),
    .pixelData     (pixelData),
    .startHistogram(startHistogram),
    .readHistogram (readHistogram),
    .xHistogramIn  (xHistogramIn),
    .yHistogramIn  (yHistogramIn),
    .xValidIn      (xValidIn),
    .yValidIn      (yValidIn),
    .xPeak         (xPeak),
    .yPeak         (yPeak),
    .xPeakCount    (xPeakCount),
    .yPeakCount    (yPeakCount)
  );

  // Frame buffer with one-cycle read latency
  logic fb [0:255];
  always @(posedge clk) pixRdData <= fb[pixAddr];

  // Histogram block model: accumulate on startHistogram, stream one beat per read cycle
  logic [7:0] xh [0:255];
  logic [7:0] yh [0:255];
  logic       hist_clr = 1'b0;
  bit         use_model = 1'b1;
  logic       sx_v [0:7];
  logic       sy_v [0:7];
  logic [7:0] sx_d [0:7];
  logic [7:0] sy_d [0:7];
  int         rd_idx = 0;

  always @(posedge clk) begin
    if (hist_clr) begin
      for (int i = 0; i < 256; i++) begin
        xh[i] <= 8'd0;
        yh[i] <= 8'd0;
      end
    end else if (startHistogram && pixelData) begin
      xh[xAddress] <= xh[xAddress] + 8'd1;
      yh[yAddress] <= yh[yAddress] + 8'd1;
    end
  end

  always @(posedge clk) begin
    if (readHistogram) begin
      if (use_model) begin
        xValidIn     <= (rd_idx < IMW);
        xHistogramIn <= xh[rd_idx];
        yValidIn     <= (rd_idx < IMH);
        yHistogramIn <= yh[rd_idx];
      end else begin
        xValidIn     <= sx_v[rd_idx];
        xHistogramIn <= sx_d[rd_idx];
        yValidIn     <= sy_v[rd_idx];
        yHistogramIn <= sy_d[rd_idx];
      end
      rd_idx <= rd_idx + 1;
    end else begin
      xValidIn     <= 1'b0;
      yValidIn     <= 1'b0;
      xHistogramIn <= 8'd0;
      yHistogramIn <= 8'd0;
      rd_idx       <= 0;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: all pixels set; mode 1: only column x=2 set
  task automatic load_frame(input int mode);
    for (int i = 0; i < 256; i++) fb[i] = 1'b0;
    for (int i = 0; i < NPIX; i++) fb[i] = (mode == 0) ? 1'b1 : ((i % IMW) == 2);
  endtask

  task automatic clear_hist();
    @(negedge clk) hist_clr = 1'b1;
    @(negedge clk) hist_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " busy"},  busy, 0);
    check_eq({tag, " done"},  done, 0);
    check_eq({tag, " pixAddr"}, pixAddr, 0);
    check_eq({tag, " xAddress"}, xAddress, 0);
    check_eq({tag, " yAddress"}, yAddress, 0);
    check_eq({tag, " startHistogram"}, startHistogram, 0);
    check_eq({tag, " readHistogram"}, readHistogram, 0);
    check_eq({tag, " xPeak"}, xPeak, 0);
    check_eq({tag, " yPeak"}, yPeak, 0);
    check_eq({tag, " xPeakCount"}, xPeakCount, 0);
    check_eq({tag, " yPeakCount"}, yPeakCount, 0);
  endtask

  // k = number of edges since the edge that sampled start; checks are taken at the negedge after edge k
  task automatic run_frame(input string name, input bit pre_started, input bit chain_next,
                           input int p1, input int p2,
                           input int ex_xp, input int ex_xc, input int ex_yp, input int ex_yc);
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int k = 0; k <= K_DONE + 1; k++) begin
      @(negedge clk);
      start = (k == p1) || (k == p2) || (chain_next && k == K_DONE + 1);
      check_eq($sformatf("%s k%0d busy", name, k), busy, (k <= K_DONE) ? 1 : 0);
      check_eq($sformatf("%s k%0d done", name, k), done, (k == K_DONE) ? 1 : 0);
      check_eq($sformatf("%s k%0d startHistogram", name, k), startHistogram,
               (k >= 1 && k <= NPIX) ? 1 : 0);
      check_eq($sformatf("%s k%0d readHistogram", name, k), readHistogram,
               (k >= NPIX + 2 && k <= NPIX + 1 + RLEN) ? 1 : 0);
      if (k < NPIX)
        check_eq($sformatf("%s k%0d pixAddr", name, k), pixAddr, k);
      if (k >= 1 && k <= NPIX) begin
        check_eq($sformatf("%s k%0d xAddress", name, k), xAddress, (k - 1) % IMW);
        check_eq($sformatf("%s k%0d yAddress", name, k), yAddress, (k - 1) / IMW);
        check_eq($sformatf("%s k%0d pixelData", name, k), pixelData, fb[k - 1]);
      end
      if (k == K_DONE) begin
        check_eq({name, " xPeak"}, xPeak, ex_xp);
        check_eq({name, " xPeakCount"}, xPeakCount, ex_xc);
        check_eq({name, " yPeak"}, yPeak, ex_yp);
        check_eq({name, " yPeakCount"}, yPeakCount, ex_yc);
      end
    end
  endtask

  initial begin
    load_frame(0);
    for (int i = 0; i < 8; i++) begin
      sx_v[i] = 1'b0; sy_v[i] = 1'b0; sx_d[i] = 8'd0; sy_d[i] = 8'd0;
    end
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle busy", busy, 0);

    // All pixels set: every x bin 3, every y bin 4 -> ties resolve to index 0
    clear_hist();
    run_frame("ones", 1'b0, 1'b0, -1, -1, 0, 3, 0, 4);

    // Hot column x=2
    load_frame(1);
    clear_hist();
    run_frame("col2", 1'b0, 1'b0, -1, -1, 2, 3, 0, 1);
    check_eq("col2 held xPeak", xPeak, 2);
    check_eq("col2 held xPeakCount", xPeakCount, 3);

    // Tie in x, all-zero y; start pulses in SCAN and READ ignored; restart right after done
    use_model = 1'b0;
    sx_d[0] = 8'd5; sx_d[1] = 8'd7; sx_d[2] = 8'd7; sx_d[3] = 8'd3; sx_d[4] = 8'd0;
    for (int i = 0; i < 5; i++) begin
      sx_v[i] = 1'b1; sy_v[i] = 1'b1; sy_d[i] = 8'd0;
    end
    run_frame("tie", 1'b0, 1'b1, 5, 16, 1, 7, 0, 0);

    // Gapped valids: x beats {1,9,2}, y beats {3,8}; invalid slots carry large junk
    sx_v[0] = 1'b1; sx_v[1] = 1'b0; sx_v[2] = 1'b1; sx_v[3] = 1'b0; sx_v[4] = 1'b1;
    sx_d[0] = 8'd1; sx_d[1] = 8'd99; sx_d[2] = 8'd9; sx_d[3] = 8'd99; sx_d[4] = 8'd2;
    sy_v[0] = 1'b0; sy_v[1] = 1'b1; sy_v[2] = 1'b0; sy_v[3] = 1'b1; sy_v[4] = 1'b0;
    sy_d[0] = 8'd50; sy_d[1] = 8'd3; sy_d[2] = 8'd60; sy_d[3] = 8'd8; sy_d[4] = 8'd70;
    run_frame("gap", 1'b1, 1'b0, -1, -1, 1, 9, 1, 8);

    // Reset mid-scan at pixel 5, then a clean full frame
    use_model = 1'b1;
    load_frame(0);
    clear_hist();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre-abort pixAddr", pixAddr, 5);
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk) reset = 1'b0;
    clear_hist();
    run_frame("rerun", 1'b0, 1'b0, -1, -1, 0, 3, 0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/histogram_frame_sequencer.md
Name: histogram_frame_sequencer

Overview:
Frame-level controller for the pixel histogram block. On a start pulse it scans the binary pixel frame buffer in raster order and drives the histogram block's address, data and update-enable inputs. It then runs the histogram readout and reduces the streamed x and y bins to a peak index and peak count per axis. It sits between the frame buffer or host control and the histogram datapath, and signals completion to the downstream tracking logic.

Parameters:
IMWIDTH, 240, frame width in pixels and number of x bins (max 256)
IMHEIGHT, 180, frame height in pixels and number of y bins (max 256)
ADDR_W, 16, frame-buffer address width (must satisfy 2^ADDR_W >= IMWIDTH*IMHEIGHT)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle frame request, sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, results valid
pixAddr  out  ADDR_W  frame-buffer read address = y*IMWIDTH + x
pixRdData  in  1  frame-buffer read data, 1-cycle latency after pixAddr
xAddress  out  8  histogram x bin address
yAddress  out  8  histogram y bin address
pixelData  out  1  pixel value to histogram block
startHistogram  out  1  histogram accumulate enable
readHistogram  out  1  histogram readout enable
xHistogramIn  in  8  streamed x bin value
yHistogramIn  in  8  streamed y bin value
xValidIn  in  1  x bin qualifier
yValidIn  in  1  y bin qualifier
xPeak  out  8  index of the largest x bin
yPeak  out  8  index of the largest y bin
xPeakCount  out  8  value of the largest x bin
yPeakCount  out  8  value of the largest y bin

Behaviour:
- Reset (async): state=IDLE; every output 0, including startHistogram, readHistogram, done, busy, peaks and counts. Internal counters 0. Reset mid-frame aborts immediately, leaves no partial results and does not clear the histogram block's memory.
- States: IDLE, SCAN, DRAIN, READ, DONE.
- IDLE: start=1 -> SCAN; x=y=0. start in any other state is ignored, with no queuing.
- SCAN: one pixel per cycle. pixAddr = y*IMWIDTH+x. x increments and wraps at IMWIDTH-1 to 0 with y+1. After the pixel (IMWIDTH-1, IMHEIGHT-1) -> DRAIN. Exactly IMWIDTH*IMHEIGHT addresses are issued.
- Alignment: xAddress, yAddress and startHistogram are pixAddr's x, y and a scan-active flag delayed 1 cycle. pixelData = pixRdData. startHistogram is high exactly IMWIDTH*IMHEIGHT cycles, contiguous.
- DRAIN: 2 cycles. Cycle 1 carries the last delayed update; cycle 2 has startHistogram=0 to let the histogram write settle. -> READ.
- READ: readHistogram=1 for R = max(IMWIDTH,IMHEIGHT)+1 cycles, then 0, -> DONE.
  - Separate bin-index counters per axis increment only on xValidIn and yValidIn beats respectively.
  - On each valid beat: if value > running max, update max and index. Strict >, so ties keep the lowest index.
  - Running max and index clear to 0 on entry to READ.
  - Only beats with valid=1 are considered; the search ends when READ ends.
- DONE: done=1 for 1 cycle. xPeak, yPeak, xPeakCount and yPeakCount are loaded and held until the next start accepted. -> IDLE.
- All-zero histogram: peaks=0, counts=0.
- Latency: done is high W*H + R + 3 cycles after the edge that samples start. With defaults: 43200+241+3 = 43444.
- busy=1 from the cycle after start is sampled through the DONE cycle.

Test Plan:
- Reset/idle: assert reset mid-SCAN at pixel 100 -> next edge-independent: all outputs 0, state IDLE; a new start then runs a full frame normally.
- Small frame (IMWIDTH=4, IMHEIGHT=3), all pixels 1 -> startHistogram high 12 cycles with (x,y) sequence (0,0)..(3,2) one cycle behind pixAddr 0..11; done at cycle 12+5+3=20.
- Single hot column x=2 with all rows 1 (IMWIDTH=4, IMHEIGHT=3), histogram model streaming bins -> xPeak=2, xPeakCount=3, yPeak=0, yPeakCount=1.
- Tie: x bins {5,7,7,...} delivered with valid -> xPeak=1, xPeakCount=7.
- Gapped valid: xValidIn low on alternate cycles with bins {1,9,2} -> indices count valid beats only; xPeak=1, xPeakCount=9.
- start pulsed during SCAN and READ -> ignored; exactly one done; start in the cycle after done is accepted.
